instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Reads 32-bit instruction words from instruction memory at the program counter and latches them into the instruction register (ir) that feeds the decoder.
- Pulses the decoder chip-select, waits for the decoder's completion ready, then advances the PC sequentially or to a branch target supplied by the flow-control unit.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 32, instruction width (decoder consumes 32)
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYC, 64, memory wait limit (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_addr  output  ADDR_W  instruction memory address (= pc)
mem_rd  output  1  memory read request, held until mem_ready
mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
mem_ready  input  1  memory read complete
ir  output  DATA_W  instruction register to decoder
cs  output  1  decoder start, one-cycle pulse
dec_ready  input  1  decoder completion ready (decoder's ready1)
br_taken  input  1  flow-control unit: branch taken
br_target  input  ADDR_W  branch destination address
stall  input  1  hold off new fetches while high
pc  output  ADDR_W  current program counter
fetch_err  output  1  sticky memory-timeout flag (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, ir=0, cs=0, mem_rd=0, fetch_err=0, br_pend=0, busy_seen=0, state=FETCH.
  - Reset mid-transaction drops mem_rd and cs in the same instant; the in-flight memory response is ignored.
- mem_addr is always combinationally equal to pc.
- FSM states: FETCH, WAIT_MEM, ISSUE, WAIT_DEC.
- FETCH:
  - If stall=1: mem_rd=0, stay.
  - Else: mem_rd<=1, go WAIT_MEM.
- WAIT_MEM:
  - mem_rd held at 1.
  - On mem_ready=1: ir<=mem_rdata, mem_rd<=0, go ISSUE.
  - mem_ready is ignored in every other state.
  - Minimum fetch latency: 1 cycle FETCH + 1 cycle WAIT_MEM when mem_ready is already high.
- ISSUE:
  - cs=1 for exactly one cycle; busy_seen<=0; go WAIT_DEC.
  - ir is stable from ISSUE until the next WAIT_MEM completion.
- WAIT_DEC:
  - The decoder reports ready while idle, so a high dec_ready is not trusted until it has been seen low.
  - dec_ready=0 sets busy_seen<=1.
  - Completion = dec_ready=1 && busy_seen=1.
  - Any br_taken=1 during WAIT_DEC sets br_pend<=1 and captures br_target into br_addr.
- Completion:
  - If br_pend (or br_taken in the same cycle), pc<=target; br_taken in the completion cycle uses br_target directly.
  - Otherwise pc<=pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
  - Clear br_pend and busy_seen, go FETCH.
- br_taken outside WAIT_DEC is ignored.
- stall is sampled only in FETCH; an in-progress transaction always completes.
- Throughput: at most one instruction in flight; no prefetch.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN
- Defined:
  - 8-bit wait counter cleared on entry to WAIT_MEM, incremented each WAIT_MEM cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYC-1 without mem_ready: fetch_err<=1 (sticky until rst), mem_rd<=0, return to FETCH, pc unchanged (retry).
  - mem_ready in that same cycle wins: normal completion, no error.
- Undefined: no counter; WAIT_MEM waits indefinitely; fetch_err tied 0.

Test Plan:
- Reset: assert rst mid-WAIT_MEM -> mem_rd, cs, fetch_err drop to 0 immediately; pc=RESET_PC; first mem_rd rises one cycle after rst release.
- Sequential fetch: memory returns 0x00200000 at addr 0 after 2-cycle latency; decoder ready low 3 cycles then high -> ir=0x00200000, single cs pulse, pc=1, next mem_rd at addr 1.
- Early ready: dec_ready held 1 through ISSUE and the first WAIT_DEC cycle, then 0, then 1 -> pc advances only after the low-then-high sequence.
- Branch: br_taken=1 with br_target=0x0040 pulsed mid WAIT_DEC -> next mem_addr=0x0040. Repeat with br_taken in the completion cycle -> same result.
- Wrap and stall: pc=0xFFFF completes -> pc=0x0000. stall=1 for 5 cycles in FETCH -> mem_rd stays 0, fetch resumes the cycle after stall falls.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=64: mem_ready never asserted -> fetch_err=1 after 64 WAIT_MEM cycles, pc unchanged, mem_rd re-asserted at the same address.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one word at pc into ir, pulses cs to the decoder, then advances pc.
// Optional memory-wait timeout with a sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic              cs,
  input  logic              dec_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_timeout_range
    $error("instr_fetch: TIMEOUT_CYC must be within 1..256");
  end

  typedef enum logic [1:0] {FETCH, WAIT_MEM, ISSUE, WAIT_DEC} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] br_addr_q, br_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              br_pend_q, br_pend_d;
  logic              busy_seen_q, busy_seen_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      br_addr_q   <= '0;
      br_pend_q   <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      br_addr_q   <= br_addr_d;
      br_pend_q   <= br_pend_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    br_addr_d   = br_addr_q;
    br_pend_d   = br_pend_q;
    busy_seen_d = busy_seen_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      FETCH: begin
        if (!stall) state_d = WAIT_MEM;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      ISSUE: begin
        busy_seen_d = 1'b0;
        state_d     = WAIT_DEC;
      end
      WAIT_DEC: begin
        // The decoder idles with ready high, so ready only counts once it has dropped.
        if (!dec_ready) busy_seen_d = 1'b1;
        if (br_taken) begin
          br_pend_d = 1'b1;
          br_addr_d = br_target;
        end
        if (dec_ready && busy_seen_q) begin
          if (br_taken)       pc_d = br_target;
          else if (br_pend_q) pc_d = br_addr_q;
          else                pc_d = pc_q + ADDR_W'(1);
          br_pend_d   = 1'b0;
          busy_seen_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Decoding the state register lets reset drop mem_rd and cs immediately.
  assign mem_rd   = (state_q == WAIT_MEM);
  assign cs       = (state_q == ISSUE);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;

endmodule
